// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-level controller: state encoding,
// default game parameters and the BCD digit type.
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int DEF_NUM_BALLS  = 3;
    localparam int DEF_WAIT_TICKS = 120;
    localparam int DEF_SCORE_MAX  = 99;

    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/pong_score_bcd.sv
// Two-digit BCD score counter: synchronous clear, increment, and saturation
// at SCORE_MAX (clear has priority over increment).
module pong_score_bcd
    import pong_pkg::*;
#(
    parameter int SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t d1,
    output bcd_t d0
);

    localparam bcd_t MAX_D1 = BCD_W'(SCORE_MAX / 10);
    localparam bcd_t MAX_D0 = BCD_W'(SCORE_MAX % 10);

    logic at_max;
    assign at_max = (d1 == MAX_D1) && (d0 == MAX_D0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= '0;
            d0 <= '0;
        end else if (clr) begin
            d1 <= '0;
            d0 <= '0;
        end else if (inc && !at_max) begin
            if (d0 == BCD_W'(9)) begin
                d0 <= '0;
                d1 <= d1 + BCD_W'(1);
            end else begin
                d0 <= d0 + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game state, balls remaining, BCD score and pause timer.
// Build option PONG_AUTO_SERVE_EN: serve a new ball as soon as the pause ends.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_BALLS  = DEF_NUM_BALLS,
    parameter int WAIT_TICKS = DEF_WAIT_TICKS,
    parameter int SCORE_MAX  = DEF_SCORE_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [1:0] balls_left,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic       timer_busy
);

    localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);
    localparam logic [7:0] TIMER_INIT = 8'(WAIT_TICKS);

    state_t     state;
    logic [7:0] timer;
    logic       serve_req;
    logic       score_clr;
    logic       score_inc;

`ifdef PONG_AUTO_SERVE_EN
    assign serve_req = 1'b1;
`else
    assign serve_req = |btn;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NEWGAME;
            balls_left <= BALLS_INIT;
            timer      <= '0;
        end else begin
            if (refr_tick && timer != 8'd0)
                timer <= timer - 8'd1;
            case (state)
                NEWGAME: begin
                    balls_left <= BALLS_INIT;
                    if (|btn) state <= PLAY;
                end
                PLAY: begin
                    // A load here overrides a coincident refresh decrement.
                    if (miss) begin
                        timer <= TIMER_INIT;
                        if (balls_left > 2'd1) begin
                            balls_left <= balls_left - 2'd1;
                            state      <= NEWBALL;
                        end else begin
                            balls_left <= 2'd0;
                            state      <= OVER;
                        end
                    end
                end
                NEWBALL: begin
                    if (timer == 8'd0 && serve_req) state <= PLAY;
                end
                OVER: begin
                    if (timer == 8'd0) begin
                        state      <= NEWGAME;
                        balls_left <= BALLS_INIT;
                    end
                end
                default: state <= NEWGAME;
            endcase
        end
    end

    // Clearing on the OVER exit edge keeps the final score visible in OVER.
    assign score_clr = (state == NEWGAME) || (state == OVER && timer == 8'd0);
    assign score_inc = (state == PLAY) && hit;

    pong_score_bcd #(.SCORE_MAX(SCORE_MAX)) u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .d1    (score_d1),
        .d0    (score_d0)
    );

    assign game_state = state;
    assign gra_still  = (state != PLAY);
    assign timer_busy = (timer != 8'd0);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scoreboard bench for pong_game_ctrl; a behavioural model predicts
// every cycle's outputs, plus explicit constant checks at key game points.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic       refr_tick, hit, miss;
    logic       gra_still, timer_busy;
    logic [1:0] game_state, balls_left;
    logic [3:0] score_d1, score_d0;

    int tests = 0;
    int fails = 0;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .refr_tick  (refr_tick),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .game_state (game_state),
        .balls_left (balls_left),
        .score_d1   (score_d1),
        .score_d0   (score_d0),
        .timer_busy (timer_busy)
    );

    always #5 clk = ~clk;

    logic [13:0] dv;
    assign dv = {game_state, gra_still, balls_left, score_d1, score_d0, timer_busy};

    localparam logic [13:0] RESET_VEC = {2'd0, 1'b1, 2'd3, 4'd0, 4'd0, 1'b0};

`ifdef PONG_AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // model state
    int ms, mb, msc, mt;
    logic [13:0] expq[$];
    string       tagq[$];

    function automatic logic [13:0] mvec();
        return {2'(ms), (ms != 1), 2'(mb), 4'(msc / 10), 4'(msc % 10), (mt != 0)};
    endfunction

    task automatic model_reset();
        ms = 0; mb = 3; msc = 0; mt = 0;
    endtask

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_f(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: model predicts, expectation queued, DUT sampled after edge.
    task automatic cyc(input logic [1:0] b, input logic r, input logic h,
                       input logic m, input string tag);
        int ns = ms, nb = mb, nsc = msc, nt = mt;
        logic [13:0] e;
        string t;
        if (r && mt != 0) nt = mt - 1;
        case (ms)
            0: begin nb = 3; nsc = 0; if (b != 0) ns = 1; end
            1: begin
                if (h) nsc = (msc < 99) ? msc + 1 : 99;
                if (m) begin
                    nt = 120;
                    if (mb > 1) begin nb = mb - 1; ns = 2; end
                    else begin nb = 0; ns = 3; end
                end
            end
            2: if (mt == 0 && (b != 0 || AUTO)) ns = 1;
            default: if (mt == 0) begin ns = 0; nsc = 0; nb = 3; end
        endcase
        ms = ns; mb = nb; msc = nsc; mt = nt;
        @(negedge clk);
        btn = b; refr_tick = r; hit = h; miss = m;
        expq.push_back(mvec());
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        t = tagq.pop_front();
        chk(t, dv, e);
        btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [1:0] b, input string tag);
        for (int i = 0; i < n; i++) cyc(b, 1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1; btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vals", dv, RESET_VEC);
        @(negedge clk);
        reset = 1'b0;

        cyc(2'b00, 0, 0, 0, "newgame_idle");
        cyc(2'b01, 0, 0, 0, "start_play");
        chk("play_entered", dv, {2'd1, 1'b0, 2'd3, 4'd0, 4'd0, 1'b0});

        for (int i = 0; i < 12; i++) cyc(2'b00, 0, 1, 0, "hit");
        chk_f("score_12", {score_d1, score_d0}, 8'h12);
        for (int i = 0; i < 87; i++) cyc(2'b00, 0, 1, 0, "hit_to_99");
        chk_f("score_99", {score_d1, score_d0}, 8'h99);
        cyc(2'b00, 0, 1, 0, "hit_sat");
        chk_f("score_sat", {score_d1, score_d0}, 8'h99);

        // miss coincident with a refresh tick: load wins
        cyc(2'b00, 1, 0, 1, "miss1");
        chk("newball_entry", dv, {2'd2, 1'b1, 2'd2, 4'd9, 4'd9, 1'b1});
        cyc(2'b10, 0, 1, 1, "newball_ignores");
        ticks(119, 2'b10, "pause_held");
        chk_f("still_paused", game_state, 2);
        chk_f("busy_119", timer_busy, 1);
        ticks(1, 2'b10, "tick120");
        chk_f("timer_done", {game_state, timer_busy}, {2'd2, 1'b0});
        cyc(2'b10, 0, 0, 0, "serve_held");
        chk_f("served", game_state, 1);

        cyc(2'b00, 0, 0, 1, "miss2");
        ticks(120, 2'b00, "pause2");
        cyc(2'b01, 0, 0, 0, "serve2");
        cyc(2'b00, 0, 0, 1, "miss3");
        chk("over_entry", dv, {2'd3, 1'b1, 2'd0, 4'd9, 4'd9, 1'b1});
        ticks(120, 2'b11, "over_btn_ignored");
        chk_f("over_hold", {game_state, score_d1, score_d0}, {2'd3, 8'h99});
        cyc(2'b00, 0, 0, 0, "over_exit");
        chk("newgame_again", dv, RESET_VEC);

        cyc(2'b11, 0, 0, 0, "start2");
        cyc(2'b00, 0, 0, 1, "miss_g2");
        ticks(120, 2'b00, "pause_g2");
        cyc(2'b01, 0, 0, 0, "serve_g2");
        cyc(2'b00, 0, 1, 1, "hit_and_miss");
        chk("hit_miss_same", dv, {2'd2, 1'b1, 2'd1, 4'd0, 4'd1, 1'b1});
        ticks(5, 2'b00, "mid_pause");

        // asynchronous reset in the middle of the pause
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", dv, RESET_VEC);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(2'b00, 0, 0, 0, "post_reset");

        cyc(2'b01, 0, 0, 0, "start3");
        cyc(2'b00, 0, 0, 1, "miss_g3");
        ticks(120, 2'b00, "pause_g3");
        cyc(2'b00, 0, 0, 0, "no_btn_after_pause");
`ifdef PONG_AUTO_SERVE_EN
        chk_f("auto_serve", game_state, 1);
`else
        chk_f("needs_button", game_state, 2);
        cyc(2'b00, 0, 0, 0, "still_waiting");
        cyc(2'b10, 0, 0, 0, "manual_serve");
        chk_f("manual_served", game_state, 1);
`endif

        if (expq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-level sequencer for the pong datapath.
- Tracks game state, balls remaining and a 2-digit BCD score.
- Freezes or releases the animated graphic generator through `gra_still`, based on button input and the hit/miss/refresh pulses the generator returns.
- Sits beside the graphic generator and VGA sync unit in the pong top level. Its outputs also feed the later text/score overlay.

Parameters:
- NUM_BALLS, 3, balls per game (1..3; `balls_left` is 2 bits)
- WAIT_TICKS, 120, refresh ticks of the pause after a miss or game over (1..255; 120 = 2 s at 60 Hz)
- SCORE_MAX, 99, score saturation value (BCD, <=99)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn  in  2  paddle buttons, level-sensitive; any bit high = "press"
- refr_tick  in  1  one-clk pulse at start of each frame, from the graphic generator
- hit  in  1  one-clk pulse: ball struck paddle
- miss  in  1  one-clk pulse: ball passed paddle
- gra_still  out  1  1 = graphic generator holds ball/paddle static
- game_state  out  2  current state encoding (NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3)
- balls_left  out  2  balls remaining
- score_d1  out  4  score tens digit (BCD)
- score_d0  out  4  score ones digit (BCD)
- timer_busy  out  1  pause timer nonzero

Behaviour:
- All state is in registers on posedge clk; async reset clears or loads them. All outputs are registered or decoded from registered state.
- Reset values:
  - state = NEWGAME, gra_still = 1
  - balls_left = NUM_BALLS
  - score_d1 = 0, score_d0 = 0
  - timer = 0, timer_busy = 0
- `gra_still` = 0 only in PLAY. It is decoded from state, so it changes on the same edge as the state.
- Pause timer (8 bit):
  - Loaded with WAIT_TICKS on any transition into NEWBALL or OVER.
  - Decrements by 1 on each `refr_tick` while nonzero; never wraps below 0.
  - `timer_busy` = (timer != 0).
- NEWGAME:
  - `balls_left` held at NUM_BALLS; score held at 0.
  - btn != 0 -> PLAY next cycle.
- PLAY:
  - hit -> score increments by 1 in BCD: d0 9->0 carries into d1; saturates at SCORE_MAX with no wrap.
  - miss with balls_left > 1 -> balls_left - 1, go to NEWBALL, load timer.
  - miss with balls_left == 1 -> balls_left = 0, go to OVER, load timer.
  - hit and miss in the same cycle -> both processed: score increments, then the miss transition applies.
- NEWBALL:
  - hit and miss ignored.
  - timer == 0 and btn != 0 -> PLAY.
  - A button held through the whole pause serves on the first cycle after the timer reaches 0.
- OVER:
  - hit, miss and btn ignored.
  - timer == 0 -> NEWGAME. Score is cleared on entry to NEWGAME so the final score stays visible during OVER.
- `refr_tick` coincident with a timer load: the load wins.
- Reset asserted mid-game: immediate return to reset values; no pending event is retained.
- Latency: every input event is reflected in state and outputs one clk after the sampling edge.

Optional Feature:
- Macro: PONG_AUTO_SERVE_EN.
- Defined: NEWBALL -> PLAY as soon as timer == 0, with no button required.
- Undefined: a button press is required, as above.
- NEWGAME and OVER behaviour is identical in both builds.

Decomposition:
- Package `pong_pkg`:
  - state encoding constants (NEWGAME/PLAY/NEWBALL/OVER)
  - default NUM_BALLS and WAIT_TICKS
  - BCD digit width
- One sub-module, `pong_score_bcd`:
  - 2-digit BCD counter with clear, inc and saturation at SCORE_MAX
  - instantiated once for the score

Test Plan:
- Reset, then btn = 2'b01 for 1 clk -> PLAY next cycle, gra_still = 0, balls_left = 3, score = 00.
- In PLAY, 12 hit pulses -> score_d1 = 1, score_d0 = 2. Preload score to 99, then 1 hit -> score stays 99.
- In PLAY, miss -> NEWBALL, balls_left = 2, gra_still = 1, timer_busy = 1. Hold btn during 119 refr_ticks -> stays NEWBALL. 120th tick -> timer 0, then PLAY on the next cycle.
- Three misses with serves between them -> OVER with balls_left = 0. After 120 refr_ticks -> NEWGAME, score = 00, balls_left = 3. btn during OVER is ignored.
- hit and miss in the same cycle with balls_left = 2 -> score +1, NEWBALL, balls_left = 1. Assert reset mid-pause -> all outputs return to reset values asynchronously.
- With PONG_AUTO_SERVE_EN defined: after a miss and 120 refr_ticks with btn = 0 -> PLAY automatically.
